// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: waits for a stable PLL lock, releases peripheral reset, then core reset.
// Optional lock-loss glitch filter enabled by defining RESET_SEQ_LOSS_FILTER_EN.
`timescale 1ns/1ps
module reset_sequencer #(
  parameter int unsigned HOLD_CYCLES    = 1024,
  parameter int unsigned STAGGER_CYCLES = 16,
  parameter int unsigned LOSS_FILTER    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked,
  output logic       periph_reset,
  output logic       core_reset,
  output logic       ready,
  output logic [7:0] loss_count
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    STAGGER   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] STAGGER_LAST = 16'(STAGGER_CYCLES - 1);

  state_t      state;
  logic [15:0] count;
  logic        sync_q1;
  logic        locked_s;
  logic        lock_lost;

  // locked is asynchronous to clk; only locked_s is used past this point.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q1  <= locked;
      locked_s <= sync_q1;
    end
  end

`ifdef RESET_SEQ_LOSS_FILTER_EN
  localparam logic [7:0] FILTER_LAST = 8'(LOSS_FILTER - 1);

  logic [7:0] filter_count;

  // Counts consecutive low samples; parks at FILTER_LAST so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      filter_count <= 8'd0;
    end else if (locked_s) begin
      filter_count <= 8'd0;
    end else if (filter_count != FILTER_LAST) begin
      filter_count <= filter_count + 8'd1;
    end
  end

  assign lock_lost = !locked_s && (filter_count == FILTER_LAST);
`else
  assign lock_lost = !locked_s;
`endif

  // Outputs are registered alongside the state so they change on the transition edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_LOCK;
      count        <= 16'd0;
      periph_reset <= 1'b1;
      core_reset   <= 1'b1;
      ready        <= 1'b0;
      loss_count   <= 8'd0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          count        <= 16'd0;
          periph_reset <= 1'b1;
          core_reset   <= 1'b1;
          ready        <= 1'b0;
          if (locked_s) begin
            state <= HOLD;
          end
        end

        HOLD: begin
          if (lock_lost) begin
            state <= WAIT_LOCK;
            count <= 16'd0;
          end else if (count == HOLD_LAST) begin
            state        <= STAGGER;
            count        <= 16'd0;
            periph_reset <= 1'b0;
          end else begin
            count <= count + 16'd1;
          end
        end

        STAGGER: begin
          if (lock_lost) begin
            state        <= WAIT_LOCK;
            count        <= 16'd0;
            periph_reset <= 1'b1;
            core_reset   <= 1'b1;
            ready        <= 1'b0;
            if (loss_count != 8'hFF) begin
              loss_count <= loss_count + 8'd1;
            end
          end else if (count == STAGGER_LAST) begin
            state      <= RUN;
            count      <= 16'd0;
            core_reset <= 1'b0;
            ready      <= 1'b1;
          end else begin
            count <= count + 16'd1;
          end
        end

        RUN: begin
          if (lock_lost) begin
            state        <= WAIT_LOCK;
            count        <= 16'd0;
            periph_reset <= 1'b1;
            core_reset   <= 1'b1;
            ready        <= 1'b0;
            if (loss_count != 8'hFF) begin
              loss_count <= loss_count + 8'd1;
            end
          end
        end

        default: begin
          state <= WAIT_LOCK;
          count <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (HOLD=16, STAGGER=4, LOSS_FILTER=4).
// Expectations adapt to whether RESET_SEQ_LOSS_FILTER_EN is defined.
`timescale 1ns/1ps
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       locked = 1'b0;
  logic       periph_reset;
  logic       core_reset;
  logic       ready;
  logic [7:0] loss_count;

  int vectors = 0;
  int miscompares = 0;
  int exp_loss = 0;

`ifdef RESET_SEQ_LOSS_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  reset_sequencer #(
    .HOLD_CYCLES   (16),
    .STAGGER_CYCLES(4),
    .LOSS_FILTER   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .locked      (locked),
    .periph_reset(periph_reset),
    .core_reset  (core_reset),
    .ready       (ready),
    .loss_count  (loss_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset with lock already present, then run 23 edges to reach RUN.
  task automatic bring_up();
    reset  = 1'b1;
    locked = 1'b1;
    repeat (3) tick();
    reset    = 1'b0;
    exp_loss = 0;
    repeat (23) tick();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    locked = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({periph_reset, core_reset, ready} !== 3'b110) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 110", {periph_reset, core_reset, ready});
    end
    vectors++;
    if (loss_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_loss_count: got %0d expected 0", loss_count);
    end
  endtask

  task automatic test_startup();
    logic exp_p, exp_c;
    reset  = 1'b1;
    locked = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int e = 0; e < 24; e++) begin
      tick();
      exp_p = (e < 18);
      exp_c = (e < 22);
      vectors++;
      if ({periph_reset, core_reset, ready} !== {exp_p, exp_c, !exp_c}) begin
        miscompares++;
        $display("FAIL startup edge %0d: got %b expected %b", e,
                 {periph_reset, core_reset, ready}, {exp_p, exp_c, !exp_c});
      end
    end
    vectors++;
    if (loss_count !== 8'd0) begin
      miscompares++;
      $display("FAIL startup_loss_count: got %0d expected 0", loss_count);
    end
  endtask

  // One-cycle lock glitch while in RUN.
  task automatic test_single_drop();
    logic exp_p, exp_c;
    locked = 1'b0;
    for (int e = 0; e < 26; e++) begin
      tick();
      if (e == 0) locked = 1'b1;
      if (FILTER_ON) begin
        exp_p = 1'b0;
        exp_c = 1'b0;
      end else begin
        exp_p = (e >= 2) && (e < 19);
        exp_c = (e >= 2) && (e < 23);
      end
      vectors++;
      if ({periph_reset, core_reset, ready} !== {exp_p, exp_c, !exp_c}) begin
        miscompares++;
        $display("FAIL single_drop edge %0d: got %b expected %b", e,
                 {periph_reset, core_reset, ready}, {exp_p, exp_c, !exp_c});
      end
    end
    if (!FILTER_ON) exp_loss++;
    vectors++;
    if (loss_count !== 8'(exp_loss)) begin
      miscompares++;
      $display("FAIL single_drop_loss_count: got %0d expected %0d", loss_count, exp_loss);
    end
  endtask

  // Five-cycle lock drop in RUN: recognised in both builds, later with the filter.
  task automatic test_long_drop();
    logic exp_p, exp_c;
    int hi_edge;
    hi_edge = FILTER_ON ? 5 : 2;
    locked  = 1'b0;
    for (int e = 0; e < 29; e++) begin
      tick();
      if (e == 4) locked = 1'b1;
      exp_p = (e >= hi_edge) && (e < 23);
      exp_c = (e >= hi_edge) && (e < 27);
      vectors++;
      if ({periph_reset, core_reset, ready} !== {exp_p, exp_c, !exp_c}) begin
        miscompares++;
        $display("FAIL long_drop edge %0d: got %b expected %b", e,
                 {periph_reset, core_reset, ready}, {exp_p, exp_c, !exp_c});
      end
    end
    exp_loss++;
    vectors++;
    if (loss_count !== 8'(exp_loss)) begin
      miscompares++;
      $display("FAIL long_drop_loss_count: got %0d expected %0d", loss_count, exp_loss);
    end
  endtask

  // Lock drops while HOLD counter is at 10; relock must wait a full HOLD period.
  task automatic test_hold_drop();
    logic exp_p, exp_c;
    reset  = 1'b1;
    locked = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    for (int e = 0; e < 41; e++) begin
      tick();
      if (e == 10) locked = 1'b0;
      if (e == 16) locked = 1'b1;
      exp_p = (e < 35);
      exp_c = (e < 39);
      vectors++;
      if ({periph_reset, core_reset, ready} !== {exp_p, exp_c, !exp_c}) begin
        miscompares++;
        $display("FAIL hold_drop edge %0d: got %b expected %b", e,
                 {periph_reset, core_reset, ready}, {exp_p, exp_c, !exp_c});
      end
    end
    vectors++;
    if (loss_count !== 8'd0) begin
      miscompares++;
      $display("FAIL hold_drop_loss_count: got %0d expected 0", loss_count);
    end
  endtask

  task automatic test_saturate();
    bit got_ready;
    bring_up();
    for (int i = 0; i < 300; i++) begin
      locked = 1'b0;
      repeat (6) tick();
      locked    = 1'b1;
      got_ready = 1'b0;
      for (int w = 0; w < 40 && !got_ready; w++) begin
        tick();
        if (ready === 1'b1) got_ready = 1'b1;
      end
      if (exp_loss < 255) exp_loss++;
      vectors++;
      if (!got_ready) begin
        miscompares++;
        $display("FAIL saturate_relock event %0d: ready got %b expected 1 within 40 edges", i, ready);
      end
      vectors++;
      if (loss_count !== 8'(exp_loss)) begin
        miscompares++;
        $display("FAIL saturate_count event %0d: got %0d expected %0d", i, loss_count, exp_loss);
      end
    end
  endtask

  // Reset asserted mid-STAGGER with loss_count non-zero from the previous test.
  task automatic test_reset_stagger();
    locked = 1'b0;
    repeat (6) tick();
    locked = 1'b1;
    repeat (20) tick();
    vectors++;
    if ({periph_reset, core_reset, ready} !== 3'b010) begin
      miscompares++;
      $display("FAIL stagger_entry: got %b expected 010", {periph_reset, core_reset, ready});
    end
    reset = 1'b1;
    tick();
    vectors++;
    if ({periph_reset, core_reset, ready, loss_count} !== {3'b110, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_in_stagger: got %b/%0d expected 110/0",
               {periph_reset, core_reset, ready}, loss_count);
    end
    reset = 1'b0;
    exp_loss = 0;
  endtask

  // Reset held while lock is lost in RUN: reset wins, nothing is counted.
  task automatic test_reset_with_loss();
    bring_up();
    reset  = 1'b1;
    locked = 1'b0;
    repeat (6) tick();
    vectors++;
    if ({periph_reset, core_reset, ready, loss_count} !== {3'b110, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_with_loss: got %b/%0d expected 110/0",
               {periph_reset, core_reset, ready}, loss_count);
    end
    reset = 1'b0;
    repeat (4) tick();
    vectors++;
    if ({periph_reset, core_reset, ready, loss_count} !== {3'b110, 8'd0}) begin
      miscompares++;
      $display("FAIL after_reset_no_lock: got %b/%0d expected 110/0",
               {periph_reset, core_reset, ready}, loss_count);
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_single_drop();
    test_long_drop();
    test_hold_drop();
    test_saturate();
    test_reset_stagger();
    test_reset_with_loss();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
